uart_rx_burst: RTL and testbench
================================

Name: uart_rx_burst

Overview:
- RS485 receive-side counterpart of the burst UART transmitter.
- Oversamples the serial line, deserialises 8N1 frames (start bit, 8 data bits LSB first, stop bit), and writes each good byte into the page-addressed frame memory.
- After BYTES good bytes it flags the packet complete and holds that flag until the enable drops; the transfer controller uses the flag as its "packet received" indication.

Parameters:
- BYTES, 4: bytes per packet; byte index wraps to 0 after BYTES-1.
- OVS, 8: clk cycles per bit (clk = OVS x baud); even, >= 4.
- TIMEOUT, 64: idle clk cycles between bytes of a partial packet before it is discarded.
- STRIDE_SH, 2: page stride shift for address generation.

Ports:
- clk  in  1  receive clock, OVS x baud.
- reset  in  1  asynchronous, active-low.
- en  in  1  receive enable from another clock domain; double-flop synchronised.
- rx  in  1  serial line from RS485 transceiver; double-flop synchronised; idle high.
- page  in  6  memory page select.
- wdata  out  8  received byte.
- waddr  out  9  write address = byte_idx + (page << STRIDE_SH), truncated mod 512.
- we  out  1  one-cycle write strobe; wdata/waddr are valid while we=1.
- done  out  1  packet complete; level signal.
- ferr  out  1  one-cycle pulse on stop-bit error.
- tout  out  1  one-cycle pulse when a partial packet is discarded on timeout.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; byte_idx=0; bit/tick counters=0; armed=0; shift=0.
  - Outputs: we=0, wdata=0, waddr=0, done=0, ferr=0, tout=0.
  - Both synchronisers preset to rx=1, en=0.
- Synchronisation: rx_s and en_s are the 2nd-stage synchroniser flops, giving 2 cycles of latency. All decisions use rx_s and en_s only.
- we, ferr and tout default to 0 every cycle unless set as described below.
- en_s=0 overrides every state, synchronously: state=IDLE, byte_idx=0, done=0, counters cleared, armed=0. No write occurs while en_s=0.
- armed is set in IDLE whenever rx_s=1. This prevents a held-low line, or the tail of a bad frame, from being taken as a start bit.
- IDLE:
  - rx_s=0 and armed=1 -> START, tick=0.
  - If byte_idx>0, an idle counter increments each cycle (cleared on leaving IDLE). When it reaches TIMEOUT-1: byte_idx=0, tout=1 for one cycle, idle counter=0.
- START:
  - tick increments each cycle.
  - At tick==OVS/2-1: if rx_s=0 -> DATA, tick=0, bit=0; otherwise glitch -> IDLE with armed=0.
- DATA:
  - tick increments each cycle.
  - At tick==OVS-1: shift[bit]=rx_s, tick=0, bit increments.
  - After sampling bit 7 -> STOP.
  - Net effect: each bit is sampled OVS/2 cycles after its nominal edge.
- STOP: at tick==OVS-1, sample rx_s.
  - rx_s=1 (good frame): registered for the next cycle are we=1, wdata=shift, waddr=byte_idx+(page<<STRIDE_SH).
    - If byte_idx==BYTES-1: byte_idx=0, done=1, go DONE.
    - Otherwise byte_idx increments, go IDLE.
  - rx_s=0 (framing error): ferr=1 for one cycle, byte discarded, byte_idx unchanged, armed=0, go IDLE.
- DONE:
  - done held at 1; line activity ignored.
  - Leaves only via en_s=0 (to IDLE, done=0).
- Page is sampled at the write cycle, not at packet start.
- The idle-counter width must hold TIMEOUT-1; tick width must hold OVS-1.
- Reset asserted mid-frame: everything returns to reset values immediately; no partial write.
- Latency: we asserts 2 (sync) + OVS/2 + 9·OVS + 1 clk after the start-bit falling edge on rx.

Test Plan:
- Reset, en=1, page=3; send 0xA5, 0x3C, 0xFF, 0x00 back-to-back at OVS=8 -> four we pulses at waddr 12,13,14,15 with wdata A5,3C,FF,00; done=1 after the 4th write. Then en=0 -> done=0 within 3 clk.
- Inject a 2-clk low glitch on rx while idle -> no we, no ferr; state returns to IDLE.
- Send 0x55 with stop bit forced 0 -> ferr pulses once, no we, byte_idx stays 0. A following good 0x81 -> written at waddr=page<<2.
- Send 2 bytes, then hold rx high for TIMEOUT cycles -> tout pulses once. Next 4 bytes write at offsets 0..3 and done=1.
- After done=1, send 2 more frames -> no we. Toggle en low then high; send 4 bytes -> normal reception from offset 0.
- Assert reset mid-DATA of the 3rd byte -> all outputs at reset values. Release reset, en=1, full packet -> addresses start at offset 0.

Source files
------------

// File: rtl/uart_rx_burst.sv
// RS485 burst receiver: oversampled 8N1 deserialiser that writes each good byte
// into page-addressed frame memory and flags completion after BYTES bytes.
module uart_rx_burst #(
   parameter int BYTES     = 4,
   parameter int OVS       = 8,
   parameter int TIMEOUT   = 64,
   parameter int STRIDE_SH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rx,
   input  logic [5:0] page,
   output logic [7:0] wdata,
   output logic [8:0] waddr,
   output logic       we,
   output logic       done,
   output logic       ferr,
   output logic       tout
);

   localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW = $clog2(OVS);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
   localparam logic [TW-1:0] HALF_T   = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] FULL_T   = TW'(OVS - 1);
   localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

   state_t        r_state;
   logic          r_rx_meta, r_rx_s, r_en_meta, r_en_s;
   logic [IW-1:0] r_idx;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_bit;
   logic [CW-1:0] r_idle;
   logic          r_armed;
   logic [7:0]    r_shift;
   logic [7:0]    r_wdata;
   logic [8:0]    r_waddr;
   logic          r_we, r_done, r_ferr, r_tout;
   logic [8:0]    w_addr;

   // Page is taken at the write cycle, so a page change mid-packet moves later bytes.
   assign w_addr = 9'(r_idx) + (9'(page) << STRIDE_SH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_en_meta <= 1'b0;
         r_en_s    <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_en_meta <= en;
         r_en_s    <= r_en_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_tick  <= '0;
         r_bit   <= '0;
         r_idle  <= '0;
         r_armed <= 1'b0;
         r_shift <= '0;
         r_wdata <= '0;
         r_waddr <= '0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
         r_tout  <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_ferr <= 1'b0;
         r_tout <= 1'b0;
         if (!r_en_s) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_tick  <= '0;
            r_bit   <= '0;
            r_idle  <= '0;
            r_armed <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // A start bit only counts once the line has been seen idle high.
                  if (r_rx_s) r_armed <= 1'b1;
                  if (!r_rx_s && r_armed) begin
                     r_state <= S_START;
                     r_tick  <= '0;
                     r_idle  <= '0;
                  end else if (r_idx != '0) begin
                     if (r_idle == IDLE_MAX) begin
                        r_idx  <= '0;
                        r_tout <= 1'b1;
                        r_idle <= '0;
                     end else begin
                        r_idle <= r_idle + 1'b1;
                     end
                  end else begin
                     r_idle <= '0;
                  end
               end
               S_START: begin
                  if (r_tick == HALF_T) begin
                     r_tick <= '0;
                     if (!r_rx_s) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                     end else begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_DATA: begin
                  if (r_tick == FULL_T) begin
                     r_shift[r_bit] <= r_rx_s;
                     r_tick         <= '0;
                     if (r_bit == 3'd7) begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                     end else begin
                        r_bit <= r_bit + 1'b1;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_STOP: begin
                  if (r_tick == FULL_T) begin
                     r_tick <= '0;
                     if (r_rx_s) begin
                        r_we    <= 1'b1;
                        r_wdata <= r_shift;
                        r_waddr <= w_addr;
                        if (r_idx == LAST_IDX) begin
                           r_idx   <= '0;
                           r_done  <= 1'b1;
                           r_state <= S_DONE;
                        end else begin
                           r_idx   <= r_idx + 1'b1;
                           r_state <= S_IDLE;
                        end
                     end else begin
                        r_ferr  <= 1'b1;
                        r_armed <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end
               S_DONE:  r_done  <= 1'b1;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign wdata = r_wdata;
   assign waddr = r_waddr;
   assign we    = r_we;
   assign done  = r_done;
   assign ferr  = r_ferr;
   assign tout  = r_tout;

endmodule

// File: tb/tb_uart_rx_burst.sv
// Bench for uart_rx_burst: frames are driven bit by bit while a packet-level model
// predicts when each write, framing error, timeout and done transition must appear.
module tb_uart_rx_burst;

   localparam int BYTES     = 4;
   localparam int OVS       = 8;
   localparam int TIMEOUT   = 64;
   localparam int STRIDE_SH = 2;
   localparam int LAT       = 2 + OVS/2 + 9*OVS + 1;

   logic       clk = 1'b0;
   logic       reset, en, rx;
   logic [5:0] page;
   logic [7:0] wdata;
   logic [8:0] waddr;
   logic       we, done, ferr, tout;

   uart_rx_burst #(.BYTES(BYTES), .OVS(OVS), .TIMEOUT(TIMEOUT), .STRIDE_SH(STRIDE_SH)) dut (
      .clk(clk), .reset(reset), .en(en), .rx(rx), .page(page),
      .wdata(wdata), .waddr(waddr), .we(we), .done(done), .ferr(ferr), .tout(tout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int kind;  // 0 write, 1 framing error, 2 timeout
      int addr;
      int data;
   } evt_t;

   evt_t q[$];
   int   cyc = 0;
   int   errors = 0, checks = 0;
   int   m_idx = 0;
   bit   m_done = 0;
   int   last_evt = 0;
   int   d_on = -1, d_off = -1;
   int   last_S = 0;
   int   wr_addr[$], wr_data[$], wr_cyc[$];
   int   n_ferr = 0, n_tout = 0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-cycle comparison against the model's event schedule.
   initial forever begin
      bit e_we, e_ferr, e_tout, e_done;
      int e_addr, e_data;
      @(negedge clk);
      e_we = 0; e_ferr = 0; e_tout = 0; e_addr = 0; e_data = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         evt_t ev;
         ev = q.pop_front();
         case (ev.kind)
            0: begin e_we = 1; e_addr = ev.addr; e_data = ev.data; end
            1: e_ferr = 1;
            default: e_tout = 1;
         endcase
      end
      e_done = (d_on >= 0 && cyc >= d_on) && !(d_off >= 0 && cyc >= d_off);
      chk("we", we, e_we);
      chk("ferr", ferr, e_ferr);
      chk("tout", tout, e_tout);
      chk("done", done, e_done);
      if (e_we) begin
         chk("waddr", waddr, e_addr);
         chk("wdata", wdata, e_data);
      end
      if (we === 1'b1) begin
         wr_addr.push_back(int'(waddr));
         wr_data.push_back(int'(wdata));
         wr_cyc.push_back(cyc);
      end
      if (ferr === 1'b1) n_ferr++;
      if (tout === 1'b1) n_tout++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A partial packet is discarded TIMEOUT cycles after its last byte if the line stays idle.
   task automatic idle_n(int n);
      rx = 1'b1;
      if (!m_done && m_idx > 0 && (last_evt + TIMEOUT < cyc + n + 3)) begin
         evt_t ev;
         ev.cyc = last_evt + TIMEOUT; ev.kind = 2; ev.addr = 0; ev.data = 0;
         q.push_back(ev);
         m_idx = 0;
      end
      repeat (n) tick();
   endtask

   task automatic send(logic [7:0] d, bit stop_ok, int gap, int abort = -1);
      logic [9:0] fr;
      int s;
      idle_n(gap);
      s = cyc;
      last_S = s;
      if (abort < 0 && !m_done) begin
         evt_t ev;
         ev.cyc = s + LAT; ev.addr = 0; ev.data = 0;
         if (stop_ok) begin
            ev.kind = 0;
            ev.addr = (m_idx + (int'(page) << STRIDE_SH)) % 512;
            ev.data = int'(d);
            m_idx++;
            if (m_idx == BYTES) begin
               m_idx = 0;
               m_done = 1;
               d_on = s + LAT;
            end
         end else begin
            ev.kind = 1;
         end
         q.push_back(ev);
         last_evt = s + LAT;
      end
      fr = {stop_ok, d, 1'b0};
      for (int c = 0; c < 10*OVS; c++) begin
         if (c == abort) return;
         rx = fr[c/OVS];
         tick();
      end
      rx = 1'b1;
   endtask

   task automatic en_toggle();
      en = 1'b0;
      d_off = cyc + 3;
      m_idx = 0;
      m_done = 0;
      repeat (3) tick();
      chk("done_drop", done, 0);
      repeat (3) tick();
      d_on = -1;
      d_off = -1;
      en = 1'b1;
      repeat (8) tick();
   endtask

   task automatic rst_mid();
      reset = 1'b0;
      q.delete();
      m_idx = 0; m_done = 0; d_on = -1; d_off = -1;
      rx = 1'b1;
      #1;
      chk("rst_we", we, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_done", done, 0);
      repeat (3) tick();
      reset = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      int n0, f0, t0, s0;
      logic [7:0] pkt [4];
      pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt[2] = 8'hFF; pkt[3] = 8'h00;
      reset = 1'b0; en = 1'b0; rx = 1'b1; page = 6'd3;
      repeat (3) tick();
      chk("reset_we", we, 0);
      chk("reset_wdata", wdata, 0);
      chk("reset_waddr", waddr, 0);
      chk("reset_done", done, 0);
      chk("reset_ferr", ferr, 0);
      chk("reset_tout", tout, 0);
      reset = 1'b1;
      en = 1'b1;
      repeat (10) tick();

      // Back-to-back packet on page 3.
      n0 = wr_addr.size();
      for (int i = 0; i < 4; i++) begin
         send(pkt[i], 1, 0);
         if (i == 0) s0 = last_S;
      end
      idle_n(4);
      chk("p1_count", wr_addr.size() - n0, 4);
      chk("p1_lat", wr_cyc[n0] - s0, 79);
      chk("p1_a0", wr_addr[n0],   12); chk("p1_d0", wr_data[n0],   8'hA5);
      chk("p1_a1", wr_addr[n0+1], 13); chk("p1_d1", wr_data[n0+1], 8'h3C);
      chk("p1_a2", wr_addr[n0+2], 14); chk("p1_d2", wr_data[n0+2], 8'hFF);
      chk("p1_a3", wr_addr[n0+3], 15); chk("p1_d3", wr_data[n0+3], 8'h00);
      chk("p1_done", done, 1);
      en_toggle();

      // Short glitch while idle.
      n0 = wr_addr.size(); f0 = n_ferr;
      rx = 1'b0; tick(); tick(); rx = 1'b1;
      idle_n(20);
      chk("glitch_we", wr_addr.size() - n0, 0);
      chk("glitch_ferr", n_ferr - f0, 0);

      // Framing error then a good byte at offset 0.
      f0 = n_ferr;
      send(8'h55, 0, 4);
      send(8'h81, 1, 6);
      idle_n(4);
      chk("ferr_count", n_ferr - f0, 1);
      chk("ferr_next_addr", wr_addr[wr_addr.size()-1], 12);
      chk("ferr_next_data", wr_data[wr_data.size()-1], 8'h81);
      en_toggle();

      // Partial packet times out, then a full packet from offset 0.
      page = 6'd5;
      t0 = n_tout;
      send(8'h11, 1, 4);
      send(8'h22, 1, 4);
      idle_n(100);
      chk("tout_count", n_tout - t0, 1);
      n0 = wr_addr.size();
      for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1, 4);
      idle_n(4);
      chk("tout_a0", wr_addr[n0], 20);
      chk("tout_a3", wr_addr[n0+3], 23);
      chk("tout_done", done, 1);

      // Frames ignored while done, then normal after enable toggle.
      n0 = wr_addr.size();
      send(8'h99, 1, 4);
      send(8'h77, 1, 4);
      idle_n(4);
      chk("done_ignore", wr_addr.size() - n0, 0);
      en_toggle();
      n0 = wr_addr.size();
      for (int i = 0; i < 4; i++) send(8'($urandom), 1, 4);
      idle_n(4);
      chk("retoggle_a0", wr_addr[n0], 20);
      en_toggle();

      // Reset in the middle of the third byte.
      page = 6'd7;
      send(8'hC3, 1, 4);
      send(8'h3C, 1, 4);
      send(8'hE7, 1, 4, 40);
      rst_mid();
      n0 = wr_addr.size();
      for (int i = 0; i < 4; i++) send(8'(8'hD0 + i), 1, 4);
      idle_n(4);
      chk("rst_a0", wr_addr[n0], 28);
      chk("rst_d0", wr_data[n0], 8'hD0);
      en_toggle();

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         int g;
         page = 6'($urandom_range(0, 63));
         g = ($urandom_range(0, 4) == 0) ? 90 + $urandom_range(0, 29) : 4 + $urandom_range(0, 19);
         send(8'($urandom), ($urandom_range(0, 7) != 0), g);
         if (m_done && $urandom_range(0, 1) == 1) begin
            idle_n(4);
            en_toggle();
         end
      end
      idle_n(100);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
